// File: rtl/kdf_sequencer_if.sv
// PRF request/response bus between the key-derivation sequencer and an
// external HMAC-PRF core.
interface kdf_sequencer_if;
  logic         prf_req;
  logic         prf_ready;
  logic [255:0] prf_key;
  logic [127:0] prf_msg;
  logic         prf_done;
  logic [255:0] prf_result;

  modport master (
    output prf_req,
    output prf_key,
    output prf_msg,
    input  prf_ready,
    input  prf_done,
    input  prf_result
  );

  modport slave (
    input  prf_req,
    input  prf_key,
    input  prf_msg,
    output prf_ready,
    output prf_done,
    output prf_result
  );
endinterface

// File: rtl/kdf_sequencer.sv
// Derives HMAC, AES and SHA keys from a root secret through an external PRF,
// checks them for zero/duplicate values and locks them until cleared.
module kdf_sequencer (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           clear_i,
  input  logic [255:0]   root_key_i,
  input  logic           root_key_valid_i,
  input  logic [63:0]    ctx_i,
  kdf_sequencer_if.master prf,
  output logic [255:0]   kdf_hmac_key_o,
  output logic [255:0]   kdf_aes_key_o,
  output logic [255:0]   kdf_sha_key_o,
  output logic           kdf_keys_valid_o,
  output logic           busy_o,
  output logic           error_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5,
    ST_CLEAR = 3'd6
  } state_e;

  localparam logic [31:0] LABEL_HMAC = 32'h484D4143;
  localparam logic [31:0] LABEL_AES  = 32'h41455320;
  localparam logic [31:0] LABEL_SHA  = 32'h53484132;
  localparam logic [1:0]  LAST_SLOT  = 2'd2;
  localparam logic [7:0]  TMO_LIMIT  = 8'hFF;

  function automatic logic [31:0] slot_label(input logic [1:0] idx);
    logic [31:0] lbl;
    case (idx)
      2'd0:    lbl = LABEL_HMAC;
      2'd1:    lbl = LABEL_AES;
      2'd2:    lbl = LABEL_SHA;
      default: lbl = 32'd0;
    endcase
    return lbl;
  endfunction

  function automatic logic keys_distinct(input logic [255:0] a,
                                         input logic [255:0] b,
                                         input logic [255:0] c);
    return (a != b) && (a != c) && (b != c);
  endfunction

  state_e       state_q, state_d;
  logic [1:0]   slot_idx_q, slot_idx_d;
  logic [7:0]   tmo_q, tmo_d;
  logic [255:0] hmac_q, hmac_d;
  logic [255:0] aes_q, aes_d;
  logic [255:0] sha_q, sha_d;

  logic         prf_req_q, prf_req_d;
  logic [255:0] prf_key_q, prf_key_d;
  logic [127:0] prf_msg_q, prf_msg_d;
  logic         busy_q, busy_d;
  logic         error_q, error_d;
  logic         valid_q, valid_d;
  logic [255:0] hmac_out_q, hmac_out_d;
  logic [255:0] aes_out_q, aes_out_d;
  logic [255:0] sha_out_q, sha_out_d;
  logic         xfer_s;

  // Next-state and slot register update; clear pre-empts every other event.
  always_comb begin
    state_d    = state_q;
    slot_idx_d = slot_idx_q;
    tmo_d      = tmo_q;
    hmac_d     = hmac_q;
    aes_d      = aes_q;
    sha_d      = sha_q;

    if (clear_i) begin
      state_d = ST_CLEAR;
      hmac_d  = 256'd0;
      aes_d   = 256'd0;
      sha_d   = 256'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i && root_key_valid_i) begin
            state_d    = ST_REQ;
            slot_idx_d = 2'd0;
          end else if (start_i) begin
            state_d = ST_ERROR;
            hmac_d  = 256'd0;
            aes_d   = 256'd0;
            sha_d   = 256'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_REQ: begin
          if (prf.prf_ready) begin
            state_d = ST_WAIT;
            tmo_d   = 8'd0;
          end else begin
            state_d = ST_REQ;
          end
        end

        ST_WAIT: begin
          if (prf.prf_done) begin
            case (slot_idx_q)
              2'd0:    hmac_d = prf.prf_result;
              2'd1:    aes_d  = prf.prf_result;
              2'd2:    sha_d  = prf.prf_result;
              default: hmac_d = hmac_q;
            endcase
            if (prf.prf_result == 256'd0) begin
              state_d = ST_ERROR;
              hmac_d  = 256'd0;
              aes_d   = 256'd0;
              sha_d   = 256'd0;
            end else if (slot_idx_q < LAST_SLOT) begin
              state_d    = ST_REQ;
              slot_idx_d = slot_idx_q + 2'd1;
            end else begin
              state_d = ST_CHECK;
            end
          end else if (tmo_q == TMO_LIMIT) begin
            state_d = ST_ERROR;
            hmac_d  = 256'd0;
            aes_d   = 256'd0;
            sha_d   = 256'd0;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end

        ST_CHECK: begin
          if (keys_distinct(hmac_q, aes_q, sha_q)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
            hmac_d  = 256'd0;
            aes_d   = 256'd0;
            sha_d   = 256'd0;
          end
        end

        ST_DONE: begin
          state_d = ST_DONE;
        end

        ST_ERROR: begin
          state_d = ST_ERROR;
          hmac_d  = 256'd0;
          aes_d   = 256'd0;
          sha_d   = 256'd0;
        end

        ST_CLEAR: begin
          state_d    = ST_IDLE;
          slot_idx_d = 2'd0;
          tmo_d      = 8'd0;
          hmac_d     = 256'd0;
          aes_d      = 256'd0;
          sha_d      = 256'd0;
        end

        default: begin
          state_d = ST_ERROR;
          hmac_d  = 256'd0;
          aes_d   = 256'd0;
          sha_d   = 256'd0;
        end
      endcase
    end
  end

  // Output values decoded from the next state so every output leaves a flop.
  always_comb begin
    xfer_s     = (state_d == ST_REQ) || (state_d == ST_WAIT);
    prf_req_d  = (state_d == ST_REQ);
    prf_key_d  = xfer_s ? root_key_i : 256'd0;
    prf_msg_d  = xfer_s ? {slot_label(slot_idx_d), ctx_i, 16'h0100, 16'h0001} : 128'd0;
    busy_d     = (state_d == ST_REQ) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
    error_d    = (state_d == ST_ERROR);
    valid_d    = (state_d == ST_DONE);
    hmac_out_d = valid_d ? hmac_d : 256'd0;
    aes_out_d  = valid_d ? aes_d  : 256'd0;
    sha_out_d  = valid_d ? sha_d  : 256'd0;
  end

  // State, slot and timeout registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      slot_idx_q <= 2'd0;
      tmo_q      <= 8'd0;
      hmac_q     <= 256'd0;
      aes_q      <= 256'd0;
      sha_q      <= 256'd0;
    end else begin
      state_q    <= state_d;
      slot_idx_q <= slot_idx_d;
      tmo_q      <= tmo_d;
      hmac_q     <= hmac_d;
      aes_q      <= aes_d;
      sha_q      <= sha_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prf_req_q  <= 1'b0;
      prf_key_q  <= 256'd0;
      prf_msg_q  <= 128'd0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      valid_q    <= 1'b0;
      hmac_out_q <= 256'd0;
      aes_out_q  <= 256'd0;
      sha_out_q  <= 256'd0;
    end else begin
      prf_req_q  <= prf_req_d;
      prf_key_q  <= prf_key_d;
      prf_msg_q  <= prf_msg_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
      valid_q    <= valid_d;
      hmac_out_q <= hmac_out_d;
      aes_out_q  <= aes_out_d;
      sha_out_q  <= sha_out_d;
    end
  end

  assign prf.prf_req       = prf_req_q;
  assign prf.prf_key       = prf_key_q;
  assign prf.prf_msg       = prf_msg_q;
  assign busy_o            = busy_q;
  assign error_o           = error_q;
  assign kdf_keys_valid_o  = valid_q;
  assign kdf_hmac_key_o    = hmac_out_q;
  assign kdf_aes_key_o     = aes_out_q;
  assign kdf_sha_key_o     = sha_out_q;

endmodule

// File: tb/tb_kdf_sequencer.sv
// Randomized bench for kdf_sequencer: a transaction-level model predicts the
// outcome, handshakes, messages and latency of each derivation.
module tb_kdf_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         clear;
  logic         rkv;
  logic [255:0] root_key;
  logic [63:0]  ctx;
  logic [255:0] hk, ak, sk;
  logic         kv, busy, err;
  int           n_tests = 0;
  int           n_fail  = 0;

  kdf_sequencer_if prf_bus ();

  kdf_sequencer dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .clear_i          (clear),
    .root_key_i       (root_key),
    .root_key_valid_i (rkv),
    .ctx_i            (ctx),
    .prf              (prf_bus),
    .kdf_hmac_key_o   (hk),
    .kdf_aes_key_o    (ak),
    .kdf_sha_key_o    (sk),
    .kdf_keys_valid_o (kv),
    .busy_o           (busy),
    .error_o          (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_msg(input int slot, input logic [63:0] c);
    logic [31:0] lbl;
    case (slot)
      0:       lbl = 32'h484D4143;
      1:       lbl = 32'h41455320;
      default: lbl = 32'h53484132;
    endcase
    return {lbl, c, 16'h0100, 16'h0001};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    check_val("clr_valid", 256'(kv), 256'd0);
    check_val("clr_error", 256'(err), 256'd0);
    check_val("clr_busy", 256'(busy), 256'd0);
    check_val("clr_keys", hk | ak | sk, 256'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("clr_idle_req", 256'(prf_bus.prf_req), 256'd0);
    check_val("clr_idle_err", 256'(err), 256'd0);
  endtask

  // One full derivation against a PRF responder with done latency d and
  // st_n cycles of backpressure on slot st_slot.
  task automatic run_derivation(input logic rk_ok, input logic [255:0] r0, input logic [255:0] r1,
                                input logic [255:0] r2, input int d, input int st_slot, input int st_n);
    logic [255:0] res [3];
    int   hs, done_cnt, lat, err_at, stall, budget, exp_hs;
    logic exp_ok, fin, zero_seen;
    res[0] = r0; res[1] = r1; res[2] = r2;
    exp_ok = rk_ok; exp_hs = 0; zero_seen = 1'b0;
    if (rk_ok) begin
      for (int i = 0; i < 3; i++) begin
        if (!zero_seen) begin
          exp_hs = i + 1;
          if (res[i] == 256'd0) zero_seen = 1'b1;
        end
      end
      if (zero_seen || r0 == r1 || r0 == r2 || r1 == r2) exp_ok = 1'b0;
    end
    hs = 0; done_cnt = 0; lat = 0; err_at = 0; stall = st_n; fin = 1'b0;
    budget = 3 * (d + 1) + st_n + 20;

    @(negedge clk);
    rkv   = rk_ok;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
      @(negedge clk);
      prf_bus.prf_done = 1'b0;
      if (kv || err) begin
        fin = 1'b1;
        if (kv)  lat    = cyc;
        if (err) err_at = cyc;
      end else begin
        check_val("keys_zero", hk | ak | sk, 256'd0);
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) begin
            prf_bus.prf_done   = 1'b1;
            prf_bus.prf_result = res[hs-1];
          end
        end
        if (prf_bus.prf_req) begin
          check_val("prf_msg", 256'(prf_bus.prf_msg), 256'(exp_msg(hs, ctx)));
          check_val("prf_key", prf_bus.prf_key, root_key);
          if (hs == st_slot && stall > 0) begin
            prf_bus.prf_ready = 1'b0;
            stall--;
          end else begin
            prf_bus.prf_ready = 1'b1;
            hs++;
            done_cnt = d;
          end
        end else begin
          prf_bus.prf_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
      end
    end
    prf_bus.prf_done  = 1'b0;
    prf_bus.prf_ready = 1'b0;

    check_val("finished", 256'(fin), 256'd1);
    check_val("handshakes", 256'(hs), 256'(exp_hs));
    check_val("valid", 256'(kv), 256'(exp_ok));
    check_val("error", 256'(err), 256'(!exp_ok));
    check_val("hmac_key", hk, exp_ok ? r0 : 256'd0);
    check_val("aes_key", ak, exp_ok ? r1 : 256'd0);
    check_val("sha_key", sk, exp_ok ? r2 : 256'd0);
    if (exp_ok) check_val("latency", 256'(lat), 256'(3 * (d + 1) + 2 + st_n));
    if (!rk_ok) check_val("err_latency", 256'(err_at), 256'd1);

    // Result is locked: further start requests must not reach the PRF.
    rkv   = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("lock_req", 256'(prf_bus.prf_req), 256'd0);
      check_val("lock_valid", 256'(kv), 256'(exp_ok));
      check_val("lock_error", 256'(err), 256'(!exp_ok));
    end
    start = 1'b0;
    do_clear();
  endtask

  task automatic begin_and_handshake();
    logic ok;
    @(negedge clk);
    rkv = 1'b1;
    start = 1'b1;
    prf_bus.prf_ready = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (prf_bus.prf_req) begin
        prf_bus.prf_ready = 1'b1;
        ok = 1'b1;
      end
    end
    check_val("hs_reached", 256'(ok), 256'd1);
    @(posedge clk);
    #1 prf_bus.prf_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] r [3];
    int first_n, mode;
    rst = 1'b1; start = 1'b0; clear = 1'b0; rkv = 1'b0;
    root_key = {32{8'hA5}}; ctx = 64'h1;
    prf_bus.prf_ready = 1'b0; prf_bus.prf_done = 1'b0; prf_bus.prf_result = 256'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_req", 256'(prf_bus.prf_req), 256'd0);
    check_val("rst_key", prf_bus.prf_key, 256'd0);
    check_val("rst_msg", 256'(prf_bus.prf_msg), 256'd0);
    check_val("rst_flags", 256'({busy, err, kv}), 256'd0);
    check_val("rst_keys", hk | ak | sk, 256'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("idle_req", 256'(prf_bus.prf_req), 256'd0);

    // Nominal, backpressure, zero result, duplicates, invalid root key.
    run_derivation(1'b1, 256'd1, 256'd2, 256'd3, 2, 0, 0);
    run_derivation(1'b1, 256'd1, 256'd2, 256'd3, 2, 1, 5);
    run_derivation(1'b1, 256'd1, 256'd0, 256'd3, 2, 0, 0);
    run_derivation(1'b1, 256'd5, 256'd5, 256'd7, 2, 0, 0);
    run_derivation(1'b0, 256'd1, 256'd2, 256'd3, 2, 0, 0);
    run_derivation(1'b1, 256'd9, 256'd8, 256'd7, 250, 2, 1);

    for (int it = 0; it < 24; it++) begin
      root_key = rand256();
      ctx      = {$urandom, $urandom};
      for (int i = 0; i < 3; i++) r[i] = rand256();
      mode = int'($urandom_range(0, 5));
      if (mode == 0) r[$urandom_range(0, 2)] = 256'd0;
      if (mode == 1) r[2] = r[$urandom_range(0, 1)];
      if (mode == 2) r[1] = r[0];
      run_derivation(($urandom_range(0, 7) != 0), r[0], r[1], r[2],
                     int'($urandom_range(1, 6)), int'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
    end

    // PRF never answers: timeout must fire around 255 cycles after handshake.
    root_key = {32{8'hA5}}; ctx = 64'h1;
    begin_and_handshake();
    first_n = 0;
    for (int n = 1; n <= 300 && first_n == 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (err) first_n = n;
    end
    check_val("tmo_window", 256'(first_n >= 250 && first_n <= 260), 256'd1);
    check_val("tmo_keys", hk | ak | sk, 256'd0);
    do_clear();

    // Clear and prf_done on the same WAIT cycle: clear wins.
    begin_and_handshake();
    @(negedge clk);
    prf_bus.prf_done = 1'b1;
    prf_bus.prf_result = rand256() | 256'd1;
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    prf_bus.prf_done = 1'b0;
    clear = 1'b0;
    check_val("prio_req", 256'(prf_bus.prf_req), 256'd0);
    check_val("prio_busy", 256'(busy), 256'd0);
    check_val("prio_err", 256'(err), 256'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("prio_idle", 256'({prf_bus.prf_req, busy, kv}), 256'd0);
    run_derivation(1'b1, 256'd11, 256'd22, 256'd33, 3, 0, 0);

    // Reset in the middle of WAIT aborts with everything zero.
    begin_and_handshake();
    @(negedge clk);
    check_val("wait_busy", 256'(busy), 256'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("mrst_req", 256'(prf_bus.prf_req), 256'd0);
    check_val("mrst_flags", 256'({busy, err, kv}), 256'd0);
    check_val("mrst_key", prf_bus.prf_key, 256'd0);
    check_val("mrst_msg", 256'(prf_bus.prf_msg), 256'd0);
    check_val("mrst_keys", hk | ak | sk, 256'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("post_rst_req", 256'(prf_bus.prf_req), 256'd0);
    run_derivation(1'b1, 256'd4, 256'd5, 256'd6, 1, 2, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
